// File: rtl/store_narrow_rmw_pkg.sv
// Shared store/load size codes and the state encoding of the narrow-store
// read-modify-write sequencer.
package store_narrow_rmw_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        ERR  = 2'b11
    } state_t;

    // A request is rejected when its size is illegal or the address is not
    // naturally aligned for that size.
    function automatic logic is_bad_request(input logic [1:0] size, input logic [1:0] offset);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_HALF: bad = offset[0];
            SZ_WORD: bad = (offset != 2'b00);
            SZ_ILL:  bad = 1'b1;
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational lane merge: drops a byte or halfword of store data into the
// addressed lanes of an existing memory word.
module store_lane_merge
    import store_narrow_rmw_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic [31:0] old_word,
    input  logic [31:0] data,
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    output logic [31:0] merged
);

    logic [1:0] lane;
    logic       upper_half;

    // Big-endian puts byte offset 0 in the top lane, so lane order is mirrored.
    always_comb begin
        lane       = BIG_ENDIAN ? (2'd3 - offset) : offset;
        upper_half = BIG_ENDIAN ? ~offset[1] : offset[1];
        merged     = old_word;
        case (size)
            SZ_BYTE: merged[{lane, 3'b000} +: 8] = data[7:0];
            SZ_HALF: begin
                if (upper_half)
                    merged[31:16] = data[15:0];
                else
                    merged[15:0]  = data[15:0];
            end
            default: merged = data;
        endcase
    end

endmodule

// File: rtl/store_narrow_rmw.sv
// Store-path sequencer: word stores go straight to memory, byte/half stores
// read the target word, merge the new lanes and write it back.
module store_narrow_rmw
    import store_narrow_rmw_pkg::*;
#(
    parameter int ADDRW      = 32,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [ADDRW-1:0] req_addr,
    input  logic [31:0]      req_data,
    input  logic [1:0]       req_size,
    output logic             done,
    output logic             misaligned,
    output logic [ADDRW-3:0] mem_addr,
    output logic             mem_rd,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_rvalid,
    output logic             mem_wr,
    output logic [31:0]      mem_wdata,
    input  logic             mem_wack
);

    state_t      state;
    logic [31:0] data_q;
    logic [1:0]  size_q;
    logic [1:0]  off_q;
    logic [31:0] merged;

    assign req_ready = (state == IDLE);

    store_lane_merge #(
        .BIG_ENDIAN(BIG_ENDIAN)
    ) u_merge (
        .old_word(mem_rdata),
        .data    (data_q),
        .size    (size_q),
        .offset  (off_q),
        .merged  (merged)
    );

    // done/misaligned are single-cycle pulses; memory strobes are held until
    // the memory side answers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            done       <= 1'b0;
            misaligned <= 1'b0;
            mem_addr   <= '0;
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            mem_wdata  <= '0;
            data_q     <= '0;
            size_q     <= SZ_BYTE;
            off_q      <= 2'b00;
        end else begin
            done       <= 1'b0;
            misaligned <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        mem_addr <= req_addr[ADDRW-1:2];
                        data_q   <= req_data;
                        size_q   <= req_size;
                        off_q    <= req_addr[1:0];
                        if (is_bad_request(req_size, req_addr[1:0])) begin
                            state <= ERR;
                        end else if (req_size == SZ_WORD) begin
                            state     <= WR;
                            mem_wdata <= req_data;
                            mem_wr    <= 1'b1;
                        end else begin
                            state  <= RD;
                            mem_rd <= 1'b1;
                        end
                    end
                end
                RD: begin
                    if (mem_rvalid) begin
                        state     <= WR;
                        mem_rd    <= 1'b0;
                        mem_wr    <= 1'b1;
                        mem_wdata <= merged;
                    end
                end
                WR: begin
                    if (mem_wack) begin
                        state  <= IDLE;
                        mem_wr <= 1'b0;
                        done   <= 1'b1;
                    end
                end
                ERR: begin
                    state      <= IDLE;
                    done       <= 1'b1;
                    misaligned <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_store_narrow_rmw.sv
// Self-checking bench for store_narrow_rmw: vector table plus a write
// scoreboard fed by a small memory model with programmable wait states.
module tb_store_narrow_rmw;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [31:0] req_data = '0;
    logic [1:0]  req_size = 2'b00;
    logic        done;
    logic        misaligned;
    logic [29:0] mem_addr;
    logic        mem_rd;
    logic [31:0] mem_rdata = '0;
    logic        mem_rvalid = 1'b0;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic        mem_wack = 1'b0;

    logic [31:0] le_old = '0;
    logic [31:0] le_data = '0;
    logic [1:0]  le_size = 2'b00;
    logic [1:0]  le_off = 2'b00;
    logic [31:0] le_merged;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
        logic [31:0] old;
        int          rd_dly;
        int          wr_dly;
        logic [31:0] exp_wdata;
        logic        exp_mis;
        logic        exp_rd;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [29:0] addr;
        logic [31:0] data;
    } wr_exp_t;

    wr_exp_t     exp_wr_q[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          rd_delay = 0;
    int          wr_delay = 0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    logic [31:0] old_word = '0;
    bit          rd_seen = 0;
    bit          wr_seen = 0;
    logic [29:0] hold_addr = '0;
    logic [31:0] hold_data = '0;

    store_narrow_rmw #(
        .ADDRW     (32),
        .BIG_ENDIAN(1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_size  (req_size),
        .done      (done),
        .misaligned(misaligned),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_rdata (mem_rdata),
        .mem_rvalid(mem_rvalid),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mem_wack  (mem_wack)
    );

    store_lane_merge #(
        .BIG_ENDIAN(1'b0)
    ) u_le_merge (
        .old_word(le_old),
        .data    (le_data),
        .size    (le_size),
        .offset  (le_off),
        .merged  (le_merged)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Memory model: answers on the falling edge so the DUT samples it on the next rising edge.
    always @(negedge clk) begin
        wr_exp_t e;
        mem_rdata = old_word;
        if (mem_rd) begin
            rd_seen    = 1;
            mem_rvalid = (rd_cnt >= rd_delay);
            rd_cnt++;
        end else begin
            mem_rvalid = 1'b0;
            rd_cnt     = 0;
        end
        if (mem_wr) begin
            wr_seen = 1;
            if (wr_cnt == 0) begin
                hold_addr = mem_addr;
                hold_data = mem_wdata;
            end else begin
                check_output("wr_addr_stable", 32'(mem_addr), 32'(hold_addr));
                check_output("wr_data_stable", mem_wdata, hold_data);
            end
            mem_wack = (wr_cnt >= wr_delay);
            if (mem_wack) begin
                if (exp_wr_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_write: got addr %h data %h, expected no write", mem_addr, mem_wdata);
                end else begin
                    e = exp_wr_q.pop_front();
                    check_output("wr_addr", 32'(mem_addr), 32'(e.addr));
                    check_output("wr_data", mem_wdata, e.data);
                end
            end
            wr_cnt++;
        end else begin
            mem_wack = 1'b0;
            wr_cnt   = 0;
        end
    end

    // Drives one request from the current time (inside the previous done cycle
    // when called back-to-back) and follows it to completion.
    task automatic apply_stimulus(input vec_t v);
        int lat;
        bit got;
        rd_delay = v.rd_dly;
        wr_delay = v.wr_dly;
        old_word = v.old;
        rd_seen  = 0;
        wr_seen  = 0;
        if (!v.exp_mis) exp_wr_q.push_back('{v.addr[31:2], v.exp_wdata});
        check_output("ready_before_accept", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_addr  = v.addr;
        req_data  = v.data;
        req_size  = v.size;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check_output("ready_busy", 32'(req_ready), 32'd0);
        check_output("done_low_after_accept", 32'(done), 32'd0);
        lat = 1;
        got = 0;
        while (!got && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            got = done;
        end
        check_output("done_seen", 32'(got), 32'd1);
        check_output("latency", lat, v.exp_lat);
        check_output("misaligned", 32'(misaligned), 32'(v.exp_mis));
        check_output("rd_issued", 32'(rd_seen), 32'(v.exp_rd));
        check_output("wr_issued", 32'(wr_seen), 32'(!v.exp_mis));
    endtask

    vec_t vecs[11];

    initial begin
        vec_t post;
        bit   saw_wr;

        //          addr          data          size   old           rd wr exp_wdata     mis   rd    lat
        vecs[0]  = '{32'h0000_1001, 32'hFFFF_FFAB, 2'b00, 32'h1122_3344, 0, 0, 32'h11AB_3344, 1'b0, 1'b1, 3};
        vecs[1]  = '{32'h0000_2002, 32'h0000_BEEF, 2'b01, 32'hCAFE_0000, 0, 0, 32'hCAFE_BEEF, 1'b0, 1'b1, 3};
        vecs[2]  = '{32'h0000_3000, 32'hDEAD_BEEF, 2'b10, 32'h5555_5555, 0, 0, 32'hDEAD_BEEF, 1'b0, 1'b0, 2};
        vecs[3]  = '{32'h0000_3001, 32'h0000_1234, 2'b01, 32'h0,         0, 0, 32'h0,         1'b1, 1'b0, 2};
        vecs[4]  = '{32'h0000_3002, 32'h1234_5678, 2'b10, 32'h0,         0, 0, 32'h0,         1'b1, 1'b0, 2};
        vecs[5]  = '{32'h0000_3004, 32'h1234_5678, 2'b11, 32'h0,         0, 0, 32'h0,         1'b1, 1'b0, 2};
        vecs[6]  = '{32'h0000_0010, 32'h0000_005A, 2'b00, 32'h1122_3344, 0, 0, 32'h5A22_3344, 1'b0, 1'b1, 3};
        vecs[7]  = '{32'h0000_0013, 32'h0000_0077, 2'b00, 32'h1122_3344, 0, 0, 32'h1122_3377, 1'b0, 1'b1, 3};
        vecs[8]  = '{32'h0000_0020, 32'hFFFF_1234, 2'b01, 32'hAABB_CCDD, 0, 0, 32'h1234_CCDD, 1'b0, 1'b1, 3};
        vecs[9]  = '{32'h0000_0042, 32'h0000_00C3, 2'b00, 32'hAABB_CCDD, 3, 2, 32'hAABB_C3DD, 1'b0, 1'b1, 8};
        vecs[10] = '{32'h8000_0004, 32'h0BAD_F00D, 2'b10, 32'h0,         0, 1, 32'h0BAD_F00D, 1'b0, 1'b0, 3};

        #12;
        check_output("rst_ready", 32'(req_ready), 32'd1);
        check_output("rst_done", 32'(done), 32'd0);
        check_output("rst_misaligned", 32'(misaligned), 32'd0);
        check_output("rst_mem_rd", 32'(mem_rd), 32'd0);
        check_output("rst_mem_wr", 32'(mem_wr), 32'd0);
        check_output("rst_mem_addr", 32'(mem_addr), 32'd0);
        check_output("rst_mem_wdata", mem_wdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Each call issues its request in the done cycle of the one before.
        for (int i = 0; i < 11; i++) apply_stimulus(vecs[i]);

        // Little-endian lane placement, checked on a standalone merge instance.
        le_old = 32'h0000_CAFE; le_data = 32'h0000_BEEF; le_size = 2'b01; le_off = 2'b00;
        #1 check_output("le_half_off0", le_merged, 32'h0000_BEEF);
        le_data = 32'h0000_1234; le_off = 2'b10;
        #1 check_output("le_half_off2", le_merged, 32'h1234_CAFE);
        le_old = 32'h1122_3344; le_data = 32'h0000_00AB; le_size = 2'b00; le_off = 2'b01;
        #1 check_output("le_byte_off1", le_merged, 32'h1122_AB44);

        // Word store parked in WR, stray requests ignored, then reset mid-write.
        wr_delay  = 1000;
        req_valid = 1'b1;
        req_addr  = 32'h0000_5000;
        req_data  = 32'h0102_0304;
        req_size  = 2'b10;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        saw_wr = 0;
        for (int i = 0; i < 5 && !saw_wr; i++) begin
            @(posedge clk);
            #1;
            saw_wr = mem_wr;
        end
        check_output("rstwr_mem_wr_up", 32'(saw_wr), 32'd1);
        req_valid = 1'b1;
        req_addr  = 32'h0000_6001;
        req_size  = 2'b11;
        repeat (2) begin
            @(posedge clk);
            #1;
            check_output("busy_ignores_req_ready", 32'(req_ready), 32'd0);
            check_output("busy_ignores_req_wr", 32'(mem_wr), 32'd1);
        end
        req_valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_output("rstwr_mem_wr", 32'(mem_wr), 32'd0);
        check_output("rstwr_ready", 32'(req_ready), 32'd1);
        check_output("rstwr_done", 32'(done), 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        exp_wr_q.delete();
        wr_delay = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            check_output("rstwr_no_done", 32'(done), 32'd0);
        end

        post = '{32'h0000_1001, 32'hFFFF_FFAB, 2'b00, 32'h1122_3344, 0, 0, 32'h11AB_3344, 1'b0, 1'b1, 3};
        apply_stimulus(post);
        post = '{32'h0000_3000, 32'hDEAD_BEEF, 2'b10, 32'h0,         0, 0, 32'hDEAD_BEEF, 1'b0, 1'b0, 2};
        apply_stimulus(post);

        @(posedge clk);
        #1;
        check_output("done_single_pulse", 32'(done), 32'd0);
        check_output("wr_queue_empty", exp_wr_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
